// File: rtl/stopwatch_ctrl.sv
// Stopwatch input conditioner and run/pause/adjust mode controller.
// Latency: raw input change -> debounced value after DB_CYCLES+2 edges, -> outputs one edge later.
// Backpressure: none; downstream blocks sample the levels and the clear pulse every clk.
//
// Ports: clk/rst (async, active-low) | raw btn_pause, btn_clear, btn_lap, sw_adj, sw_sel
//        -> pause, adj, sel, clear (1-cycle pulse), freeze (lap hold), state[1:0].
// Optional feature macro: STOPWATCH_CTRL_LAP_EN enables the lap button and the freeze level;
// without it btn_lap is ignored and freeze is tied low.

module stopwatch_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       pause,
    output logic       adj,
    output logic       sel,
    output logic       clear,
    output logic       freeze,
    output logic [1:0] state
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_PAUSED = 2'b01;
    localparam logic [1:0] ST_ADJUST = 2'b10;

    // Input lane indices into the conditioning vectors.
    localparam int I_PAUSE = 0;
    localparam int I_CLEAR = 1;
    localparam int I_ADJ   = 2;
    localparam int I_SEL   = 3;
`ifdef STOPWATCH_CTRL_LAP_EN
    localparam int I_LAP   = 4;
    localparam int NIN     = 5;
`else
    localparam int NIN     = 4;
`endif

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

    logic [NIN-1:0]  raw;
    logic [NIN-1:0]  sync1_q, sync2_q, db_q;
    logic [DB_W-1:0] cnt_q [NIN];

    assign raw[I_PAUSE] = btn_pause;
    assign raw[I_CLEAR] = btn_clear;
    assign raw[I_ADJ]   = sw_adj;
    assign raw[I_SEL]   = sw_sel;
`ifdef STOPWATCH_CTRL_LAP_EN
    assign raw[I_LAP]   = btn_lap;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    // Two-flop synchronizer followed by a per-lane debouncer. The counter tracks how
    // many consecutive cycles the synchronized value has disagreed with the debounced
    // one; the debounced value flips on the DB_CYCLES-th disagreeing cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NIN; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    db_q[i]  <= ~db_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Previous debounced button values for rising-edge (press) detection.
    logic pause_prev_q, clear_prev_q;
    logic pause_press, clear_press;
    assign pause_press = db_q[I_PAUSE] & ~pause_prev_q;
    assign clear_press = db_q[I_CLEAR] & ~clear_prev_q;

    logic [1:0] state_q, state_d;
    logic       ret_q, ret_d;
    logic       pause_q, adj_q, sel_q, clear_q, freeze_q, freeze_d;

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            ST_RUN: begin
                if (db_q[I_ADJ]) begin
                    state_d = ST_ADJUST;
                    ret_d   = 1'b0;
                end else if (pause_press) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (db_q[I_ADJ]) begin
                    state_d = ST_ADJUST;
                    ret_d   = 1'b1;
                end else if (pause_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!db_q[I_ADJ]) begin
                    state_d = ret_q ? ST_PAUSED : ST_RUN;
                end else if (pause_press) begin
                    // A pause press while adjusting chooses where adjust will return to.
                    ret_d = ~ret_q;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_prev_q;
    logic lap_press;
    assign lap_press = db_q[I_LAP] & ~lap_prev_q;

    always_comb begin
        freeze_d = freeze_q;
        if (lap_press) begin
            if (state_q == ST_RUN)         freeze_d = ~freeze_q;
            else if (state_q == ST_PAUSED) freeze_d = 1'b0;
        end
        // Entering adjust or clearing always releases the lap hold; clear beats lap.
        if ((state_d == ST_ADJUST && state_q != ST_ADJUST) || clear_press) freeze_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lap_prev_q <= 1'b0;
        else      lap_prev_q <= db_q[I_LAP];
    end
`else
    assign freeze_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            ret_q        <= 1'b0;
            pause_q      <= 1'b0;
            adj_q        <= 1'b0;
            sel_q        <= 1'b0;
            clear_q      <= 1'b0;
            freeze_q     <= 1'b0;
            pause_prev_q <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            // Decoded from the next state so they move together with state.
            pause_q      <= (state_d == ST_PAUSED);
            adj_q        <= (state_d == ST_ADJUST);
            sel_q        <= db_q[I_SEL];
            clear_q      <= clear_press;
            freeze_q     <= freeze_d;
            pause_prev_q <= db_q[I_PAUSE];
            clear_prev_q <= db_q[I_CLEAR];
        end
    end

    assign state  = state_q;
    assign pause  = pause_q;
    assign adj    = adj_q;
    assign sel    = sel_q;
    assign clear  = clear_q;
    assign freeze = freeze_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios plus randomized stimulus
// compared every cycle against a behavioural model.
// Runs with DB_CYCLES=4, DB_W=3.

module tb_stopwatch_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_pause = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
    logic       pause, adj, sel, clear, freeze;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;
    bit mdl_cmp_en = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DB_CYCLES(DB), .DB_W(3)) dut (
        .clk(clk), .rst(rst),
        .btn_pause(btn_pause), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .sw_adj(sw_adj), .sw_sel(sw_sel),
        .pause(pause), .adj(adj), .sel(sel), .clear(clear), .freeze(freeze),
        .state(state)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Lanes: 0 pause, 1 clear, 2 adj, 3 sel, 4 lap. Modes: 0 run, 1 paused, 2 adjust.
    bit m_s1 [5], m_s2 [5], m_db [5], m_dbp [5];
    bit m_hist [5][DB];   // last DB synchronized samples, oldest first
    int m_mode;
    bit m_back_paused;
    bit m_pause, m_adj, m_sel, m_clear, m_freeze;

    function automatic bit raw_in(int i);
        case (i)
            0: return btn_pause;
            1: return btn_clear;
            2: return sw_adj;
            3: return sw_sel;
            default: return btn_lap;
        endcase
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 5; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbp[i] = 0;
            for (int k = 0; k < DB; k++) m_hist[i][k] = 0;
        end
        m_mode = 0; m_back_paused = 0;
        m_pause = 0; m_adj = 0; m_sel = 0; m_clear = 0; m_freeze = 0;
    endtask

    task automatic mdl_step();
        bit pp, cp, lp, a, all_diff;
        int nmode;
        bit nback, nfr;
        pp = m_db[0] && !m_dbp[0];
        cp = m_db[1] && !m_dbp[1];
        lp = m_db[4] && !m_dbp[4];
        a  = m_db[2];
        nmode = m_mode;
        nback = m_back_paused;
        if (m_mode == 2) begin
            if (!a)      nmode = m_back_paused ? 1 : 0;
            else if (pp) nback = !m_back_paused;
        end else if (a) begin
            nback = (m_mode == 1);
            nmode = 2;
        end else if (pp) begin
            nmode = 1 - m_mode;
        end
`ifdef STOPWATCH_CTRL_LAP_EN
        nfr = m_freeze;
        if (lp && m_mode == 0) nfr = !m_freeze;
        if (lp && m_mode == 1) nfr = 0;
        if ((nmode == 2 && m_mode != 2) || cp) nfr = 0;
`else
        nfr = 0;
        lp  = 0;
`endif
        m_clear = cp;
        m_sel   = m_db[3];
        m_pause = (nmode == 1);
        m_adj   = (nmode == 2);
        m_mode  = nmode;
        m_back_paused = nback;
        m_freeze = nfr;
        // A lane's debounced value flips once DB consecutive synchronized samples disagree with it.
        for (int i = 0; i < 5; i++) begin
            m_dbp[i] = m_db[i];
            for (int k = 0; k < DB - 1; k++) m_hist[i][k] = m_hist[i][k+1];
            m_hist[i][DB-1] = m_s2[i];
            all_diff = 1;
            for (int k = 0; k < DB; k++) if (m_hist[i][k] == m_db[i]) all_diff = 0;
            if (all_diff) m_db[i] = !m_db[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw_in(i);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) mdl_reset();
        else      mdl_step();
    end

    always @(negedge clk) begin
        if (rst && mdl_cmp_en) begin
            chk("m_state",  {6'd0, state},  8'(m_mode));
            chk("m_pause",  {7'd0, pause},  {7'd0, m_pause});
            chk("m_adj",    {7'd0, adj},    {7'd0, m_adj});
            chk("m_sel",    {7'd0, sel},    {7'd0, m_sel});
            chk("m_clear",  {7'd0, clear},  {7'd0, m_clear});
            chk("m_freeze", {7'd0, freeze}, {7'd0, m_freeze});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        btn_pause = 0; btn_clear = 0; btn_lap = 0; sw_adj = 0; sw_sel = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_state"},  {6'd0, state}, 8'd0);
        chk({tag, "_pause"},  {7'd0, pause}, 8'd0);
        chk({tag, "_adj"},    {7'd0, adj},   8'd0);
        chk({tag, "_sel"},    {7'd0, sel},   8'd0);
        chk({tag, "_clear"},  {7'd0, clear}, 8'd0);
        chk({tag, "_freeze"}, {7'd0, freeze}, 8'd0);
    endtask

    int pulses;

    initial begin
        mdl_cmp_en = 1'b1;
        // Reset state
        do_reset();
        chk_outputs_reset("rst");

        // Glitch of 3 cycles on pause is rejected
        btn_pause = 1;
        repeat (3) @(negedge clk);
        btn_pause = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("glitch_state", {6'd0, state}, 8'd0);
            chk("glitch_pause", {7'd0, pause}, 8'd0);
        end

        // Pause toggle: change just after edge 0, takes effect at edge 7
        btn_pause = 1;
        repeat (6) @(negedge clk);
        chk("pause_e6_state", {6'd0, state}, 8'd0);
        @(negedge clk);
        chk("pause_e7_state", {6'd0, state}, 8'd1);
        chk("pause_e7_pause", {7'd0, pause}, 8'd1);
        btn_pause = 0;
        repeat (8) @(negedge clk);
        btn_pause = 1;
        repeat (7) @(negedge clk);
        chk("resume_state", {6'd0, state}, 8'd0);
        chk("resume_pause", {7'd0, pause}, 8'd0);
        btn_pause = 0;
        repeat (8) @(negedge clk);

        // Adjust entered from PAUSED, ret toggled by a press, leaves to RUN
        btn_pause = 1;
        repeat (8) @(negedge clk);
        btn_pause = 0;
        repeat (8) @(negedge clk);
        chk("adjpre_state", {6'd0, state}, 8'd1);
        sw_adj = 1;
        repeat (6) @(negedge clk);
        chk("adj_e6_state", {6'd0, state}, 8'd1);
        @(negedge clk);
        chk("adj_e7_state", {6'd0, state}, 8'd2);
        chk("adj_e7_adj",   {7'd0, adj},   8'd1);
        chk("adj_e7_pause", {7'd0, pause}, 8'd0);
        btn_pause = 1;
        repeat (8) @(negedge clk);
        btn_pause = 0;
        repeat (8) @(negedge clk);
        chk("adj_hold_state", {6'd0, state}, 8'd2);
        sw_adj = 0;
        repeat (7) @(negedge clk);
        chk("adjret_state", {6'd0, state}, 8'd0);
        chk("adjret_pause", {7'd0, pause}, 8'd0);
        chk("adjret_adj",   {7'd0, adj},   8'd0);

        // Async reset mid-ADJUST, between edges
        sw_adj = 1;
        sw_sel = 1;
        repeat (10) @(negedge clk);
        chk("pre_arst_state", {6'd0, state}, 8'd2);
        chk("pre_arst_sel",   {7'd0, sel},   8'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_outputs_reset("arst");
        do_reset();

        // Long clear hold gives exactly one pulse at edge 7, state unchanged
        btn_clear = 1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 7) chk("clear_e7", {7'd0, clear}, 8'd1);
            if (clear) pulses++;
        end
        chk("clear_pulses", 8'(pulses), 8'd1);
        chk("clear_state",  {6'd0, state}, 8'd0);
        btn_clear = 0;
        repeat (8) @(negedge clk);

        // Simultaneous clear and pause press
        btn_clear = 1;
        btn_pause = 1;
        repeat (7) @(negedge clk);
        chk("cp_clear", {7'd0, clear}, 8'd1);
        chk("cp_state", {6'd0, state}, 8'd1);
        btn_clear = 0;
        btn_pause = 0;
        do_reset();

`ifdef STOPWATCH_CTRL_LAP_EN
        btn_lap = 1;
        repeat (7) @(negedge clk);
        chk("lap_freeze", {7'd0, freeze}, 8'd1);
        btn_lap = 0;
        repeat (8) @(negedge clk);
        btn_clear = 1;
        repeat (7) @(negedge clk);
        chk("lapclr_freeze", {7'd0, freeze}, 8'd0);
        chk("lapclr_clear",  {7'd0, clear},  8'd1);
        btn_clear = 0;
`else
        for (int c = 0; c < 40; c++) begin
            btn_lap = (c / 6) % 2 == 0;
            @(negedge clk);
            chk("nolap_freeze", {7'd0, freeze}, 8'd0);
        end
        btn_lap = 0;
`endif
        do_reset();

        // Randomized stimulus; the model comparison runs every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0)  btn_pause = ~btn_pause;
            if ($urandom_range(0, 9) == 0)  btn_clear = ~btn_clear;
            if ($urandom_range(0, 7) == 0)  btn_lap   = ~btn_lap;
            if ($urandom_range(0, 29) == 0) sw_adj    = ~sw_adj;
            if ($urandom_range(0, 15) == 0) sw_sel    = ~sw_sel;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Input-conditioning and mode controller for the stopwatch. It synchronizes and debounces the raw board buttons and switches, then runs the run/pause/adjust state machine. It drives the `pause`, `adj` and `sel` controls consumed by the clock divider, counter and display blocks, plus a one-cycle `clear` pulse and a lap `freeze` level. It sits in the top level between the board pins and those blocks.

## Interface

Parameters:
- `DB_CYCLES`, default 1000000: consecutive `clk` cycles a synchronized input must differ from its debounced value before the debounced value updates (10 ms at 100 MHz).
- `DB_W`, default 20: width of each debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_pause`  in  1  raw pause/resume button, asynchronous.
- `btn_clear`  in  1  raw clear button, asynchronous.
- `btn_lap`  in  1  raw lap button, asynchronous; used only with `STOPWATCH_CTRL_LAP_EN`.
- `sw_adj`  in  1  raw adjust-mode switch, asynchronous.
- `sw_sel`  in  1  raw minutes/seconds select switch, asynchronous.
- `pause`  out  1  high while in PAUSED.
- `adj`  out  1  high while in ADJUST.
- `sel`  out  1  registered debounced `sw_sel`.
- `clear`  out  1  one-cycle pulse per debounced `btn_clear` press.
- `freeze`  out  1  lap hold level for the display.
- `state`  out  2  current FSM state: RUN=2'b00, PAUSED=2'b01, ADJUST=2'b10.

## Operation

- Each of the 5 raw inputs passes through a 2-flop synchronizer, then its own debouncer.
- Debouncer behaviour:
  - While the synchronized value equals the debounced value, the counter holds at 0.
  - While they differ, the counter increments.
  - When the counter reaches DB_CYCLES-1 while the values still differ, the debounced value flips and the counter returns to 0.
  - Any cycle where the values agree resets the counter to 0. Glitches shorter than DB_CYCLES cycles are therefore rejected.
- Press pulses: a rising edge of a debounced button produces a 1-cycle internal pulse. Falling edges produce nothing.
- FSM (registered; `ret` is a 1-bit saved return state, 0=RUN, 1=PAUSED):
  - RUN: if debounced adj is 1, go to ADJUST with `ret`=0. Otherwise a pause press goes to PAUSED.
  - PAUSED: if debounced adj is 1, go to ADJUST with `ret`=1. Otherwise a pause press goes to RUN.
  - ADJUST: if debounced adj is 0, go to RUN when `ret`=0, else PAUSED. Otherwise a pause press toggles `ret`.
  - Adj level has priority over a pause press in the same cycle. In that case the press is dropped, except in ADJUST.
  - State 2'b11 is unreachable; if ever entered, the next state is RUN.
- `pause` and `adj` are registered decodes of the next state, so they change in the same cycle as `state`.
- `clear` fires on every clear press in any state and does not change FSM state. A clear press in the same cycle as a pause press has both effects applied.

## Timing

- Reset (asynchronous assert, `rst`=0), all values are forced immediately:
  - state=RUN, `ret`=0
  - `pause`=0, `adj`=0, `sel`=0, `clear`=0, `freeze`=0
  - all synchronizer flops, debounced values and counters = 0
- Reset mid-debounce discards the partial count. A switch held high through reset reaches the outputs after full debounce latency.
- Latency: a raw input change held stable at edge N updates its debounced value at edge N+DB_CYCLES+2. The resulting output or state change registers at edge N+DB_CYCLES+3.
- `clear` is exactly 1 cycle wide per press, however long the button is held.
- No handshake: downstream blocks sample levels and the pulse on `clk`.

## Configuration

- Macro: `STOPWATCH_CTRL_LAP_EN`.
- Defined: `btn_lap` is synchronized and debounced like the other buttons, with these rules:
  - A lap press in RUN toggles `freeze`.
  - A lap press in PAUSED sets `freeze`=0.
  - Entering ADJUST or a clear press forces `freeze`=0. Clear wins over a simultaneous lap press.
- Not defined: `btn_lap` is ignored (no synchronizer or debouncer logic) and `freeze` is tied to 0.

## Test plan

All scenarios run with DB_CYCLES=4 and DB_W=3.
- Reset/glitch: assert `rst`=0, then release; pulse `btn_pause` high for 3 cycles -> `state`=00 and `pause`=0 throughout, no transition.
- Pause toggle: hold `btn_pause` high from edge 0 -> `state`=01 and `pause`=1 at edge 7. Release, then press again -> `state`=00 and `pause`=0.
- Adjust return: from PAUSED set `sw_adj`=1 -> `adj`=1, `state`=10 at edge 7. Press pause (`ret`=0), then set `sw_adj`=0 -> `state`=00, `pause`=0.
- Clear: hold `btn_clear` for 20 cycles in RUN -> exactly one `clear` pulse at edge 7, `state` unchanged. A simultaneous clear and pause press -> one `clear` pulse plus a transition to PAUSED.
- Lap (`STOPWATCH_CTRL_LAP_EN` defined): in RUN press lap -> `freeze`=1. Press clear -> `freeze`=0 and `clear`=1 in the same cycle. Without the macro, `freeze` stays 0 under all lap stimulus.
- Async reset mid-ADJUST: drive `rst`=0 between clock edges -> outputs go to reset values before the next edge.
